// File: rtl/fm_pingpong_buf_if.sv
// Handshake/data bundle between the ping-pong feature-map buffer and the
// producer/consumer layers. The buffer side uses the slave modport.
interface fm_pingpong_buf_if #(
    parameter int DATA_W = 1024,
    parameter int ADDR_W = 5
);
    // producer side
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_done;
    logic              wr_ready;
    // consumer side
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_done;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_vld;
    // status
    logic              wr_bank;
    logic              rd_bank;
    logic              err;

    modport master (
        output wr_en, wr_addr, wr_data, wr_done,
        output rd_en, rd_addr, rd_done,
        input  wr_ready, rd_ready, rd_data, rd_vld,
        input  wr_bank, rd_bank, err
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_done,
        input  rd_en, rd_addr, rd_done,
        output wr_ready, rd_ready, rd_data, rd_vld,
        output wr_bank, rd_bank, err
    );
endinterface

// File: rtl/fm_pingpong_buf.sv
// Two-bank (ping-pong) feature-map buffer. The producer fills the bank at
// wr_sel while the consumer drains the bank at rd_sel; a bank changes owner
// when its done pulse is accepted. Read data returns after RD_LAT cycles
// (1 or 2) with a matching rd_vld pulse.
module fm_pingpong_buf #(
    parameter int DATA_W = 1024,
    parameter int ADDR_W = 5,
    parameter int RD_LAT = 1
) (
    input logic              clk,
    input logic              rst,
    fm_pingpong_buf_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    // bank ownership state
    logic [1:0]        full_q,   full_d;
    logic              wr_sel_q, wr_sel_d;
    logic              rd_sel_q, rd_sel_d;
    logic              err_q,    err_d;

    // first read stage (present for both latencies)
    logic [DATA_W-1:0] s1_data_q, s1_data_d;
    logic              s1_vld_q,  s1_vld_d;

    // decoded handshakes
    logic              wr_ready;
    logic              rd_ready;
    logic              wr_fire;
    logic              wr_close;
    logic              rd_fire;
    logic              rd_close;

    logic [DATA_W-1:0] mem [2][DEPTH];

    // Handshake decode: ready flags come straight from registered state.
    always_comb begin
        wr_ready = ~full_q[wr_sel_q];
        rd_ready =  full_q[rd_sel_q];
        wr_fire  = bus.wr_en   & wr_ready;
        wr_close = bus.wr_done & wr_ready;
        rd_fire  = bus.rd_en   & rd_ready;
        rd_close = bus.rd_done & rd_ready;
    end

    // Next-state for bank flags, pointers and the sticky error flag.
    always_comb begin
        // NOTE: every comb output gets a default first so no latch is inferred.
        full_d   = full_q;
        wr_sel_d = wr_sel_q;
        rd_sel_d = rd_sel_q;
        // Write and read closes always hit different banks, so both may apply.
        if (wr_close) begin
            full_d[wr_sel_q] = 1'b1;
            wr_sel_d         = ~wr_sel_q;
        end
        if (rd_close) begin
            full_d[rd_sel_q] = 1'b0;
            rd_sel_d         = ~rd_sel_q;
        end
        err_d = err_q
              | ((bus.wr_en | bus.wr_done) & ~wr_ready)
              | ((bus.rd_en | bus.rd_done) & ~rd_ready);
    end

    // Next-state for the first read stage; data holds when no read is accepted.
    always_comb begin
        s1_vld_d  = rd_fire;
        s1_data_d = s1_data_q;
        if (rd_fire) begin
            s1_data_d = mem[rd_sel_q][bus.rd_addr];
        end
    end

    // Control and first read stage registers.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples pre-edge values regardless of statement order.
        if (rst) begin
            full_q    <= 2'b00;
            wr_sel_q  <= 1'b0;
            rd_sel_q  <= 1'b0;
            err_q     <= 1'b0;
            s1_vld_q  <= 1'b0;
            s1_data_q <= '0;
        end else begin
            full_q    <= full_d;
            wr_sel_q  <= wr_sel_d;
            rd_sel_q  <= rd_sel_d;
            err_q     <= err_d;
            s1_vld_q  <= s1_vld_d;
            s1_data_q <= s1_data_d;
        end
    end

    // RAM write port into the bank currently owned by the producer.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately left out of reset so it maps onto RAM.
        if (wr_fire) begin
            mem[wr_sel_q][bus.wr_addr] <= bus.wr_data;
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] s2_data_q, s2_data_d;
            logic              s2_vld_q,  s2_vld_d;

            // Output register stage; holds data between valid pulses.
            always_comb begin
                s2_vld_d  = s1_vld_q;
                s2_data_d = s1_vld_q ? s1_data_q : s2_data_q;
            end

            // Output register stage flops, flushed by reset.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s2_vld_q  <= 1'b0;
                    s2_data_q <= '0;
                end else begin
                    s2_vld_q  <= s2_vld_d;
                    s2_data_q <= s2_data_d;
                end
            end

            assign bus.rd_vld  = s2_vld_q;
            assign bus.rd_data = s2_data_q;
        end else begin : g_lat1
            assign bus.rd_vld  = s1_vld_q;
            assign bus.rd_data = s1_data_q;
        end
    endgenerate

    // Status outputs.
    always_comb begin
        bus.wr_ready = wr_ready;
        bus.rd_ready = rd_ready;
        bus.wr_bank  = wr_sel_q;
        bus.rd_bank  = rd_sel_q;
        bus.err      = err_q;
    end
endmodule

// File: tb/tb_fm_pingpong_buf.sv
// Self-checking bench: one RD_LAT=1 and one RD_LAT=2 buffer receive identical
// stimulus; a bank/queue reference model predicts every output each cycle.
module tb_fm_pingpong_buf;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 1 << AW;

    logic          clk     = 1'b0;
    logic          rst     = 1'b1;
    logic          wr_en   = 1'b0;
    logic          wr_done = 1'b0;
    logic          rd_en   = 1'b0;
    logic          rd_done = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] wr_data = '0;

    always #5 clk = ~clk;

    fm_pingpong_buf_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();
    fm_pingpong_buf_if #(.DATA_W(DW), .ADDR_W(AW)) bus2 ();

    assign bus1.wr_en   = wr_en;
    assign bus1.wr_addr = wr_addr;
    assign bus1.wr_data = wr_data;
    assign bus1.wr_done = wr_done;
    assign bus1.rd_en   = rd_en;
    assign bus1.rd_addr = rd_addr;
    assign bus1.rd_done = rd_done;
    assign bus2.wr_en   = wr_en;
    assign bus2.wr_addr = wr_addr;
    assign bus2.wr_data = wr_data;
    assign bus2.wr_done = wr_done;
    assign bus2.rd_en   = rd_en;
    assign bus2.rd_addr = rd_addr;
    assign bus2.rd_done = rd_done;

    fm_pingpong_buf #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    fm_pingpong_buf #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    // Reference model: two banks, full flags, bank pointers, pending reads.
    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } rd_item_t;

    logic [DW-1:0] m_mem [2][DEPTH];
    bit            m_full [2];
    bit            m_wsel;
    bit            m_rsel;
    bit            m_err;
    rd_item_t      q1[$];
    rd_item_t      q2[$];
    logic [DW-1:0] last1 = '0;
    logic [DW-1:0] last2 = '0;
    int            cycle    = 0;
    int            checks   = 0;
    int            failures = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    task automatic idle();
        wr_en   = 1'b0;
        wr_done = 1'b0;
        rd_en   = 1'b0;
        rd_done = 1'b0;
    endtask

    task automatic model_reset();
        m_full[0] = 1'b0;
        m_full[1] = 1'b0;
        m_wsel    = 1'b0;
        m_rsel    = 1'b0;
        m_err     = 1'b0;
        q1.delete();
        q2.delete();
        last1     = '0;
        last2     = '0;
    endtask

    // Compare every output of both DUTs against the model for this cycle.
    task automatic compare_outputs();
        bit v1 = 1'b0;
        bit v2 = 1'b0;
        if (q1.size() != 0 && q1[0].due == cycle) begin
            v1    = 1'b1;
            last1 = q1[0].data;
            void'(q1.pop_front());
        end
        if (q2.size() != 0 && q2[0].due == cycle) begin
            v2    = 1'b1;
            last2 = q2[0].data;
            void'(q2.pop_front());
        end
        check("l1_wr_ready", DW'(bus1.wr_ready), DW'(!m_full[m_wsel]));
        check("l1_rd_ready", DW'(bus1.rd_ready), DW'(m_full[m_rsel]));
        check("l1_wr_bank",  DW'(bus1.wr_bank),  DW'(m_wsel));
        check("l1_rd_bank",  DW'(bus1.rd_bank),  DW'(m_rsel));
        check("l1_err",      DW'(bus1.err),      DW'(m_err));
        check("l1_rd_vld",   DW'(bus1.rd_vld),   DW'(v1));
        check("l1_rd_data",  bus1.rd_data,       last1);
        check("l2_wr_ready", DW'(bus2.wr_ready), DW'(!m_full[m_wsel]));
        check("l2_rd_ready", DW'(bus2.rd_ready), DW'(m_full[m_rsel]));
        check("l2_wr_bank",  DW'(bus2.wr_bank),  DW'(m_wsel));
        check("l2_rd_bank",  DW'(bus2.rd_bank),  DW'(m_rsel));
        check("l2_err",      DW'(bus2.err),      DW'(m_err));
        check("l2_rd_vld",   DW'(bus2.rd_vld),   DW'(v2));
        check("l2_rd_data",  bus2.rd_data,       last2);
    endtask

    // Apply the current inputs to the model, clock once, then compare.
    task automatic step();
        bit wr_rdy = !m_full[m_wsel];
        bit rd_rdy = m_full[m_rsel];
        if (!rst) begin
            if ((wr_en || wr_done) && !wr_rdy) m_err = 1'b1;
            if ((rd_en || rd_done) && !rd_rdy) m_err = 1'b1;
            if (rd_en && rd_rdy) begin
                q1.push_back('{due: cycle + 1, data: m_mem[m_rsel][rd_addr]});
                q2.push_back('{due: cycle + 2, data: m_mem[m_rsel][rd_addr]});
            end
            if (wr_en && wr_rdy) m_mem[m_wsel][wr_addr] = wr_data;
            if (wr_done && wr_rdy) begin
                m_full[m_wsel] = 1'b1;
                m_wsel         = !m_wsel;
            end
            if (rd_done && rd_rdy) begin
                m_full[m_rsel] = 1'b0;
                m_rsel         = !m_rsel;
            end
        end
        @(posedge clk);
        #1;
        cycle++;
        compare_outputs();
    endtask

    task automatic apply_reset();
        idle();
        rst = 1'b1;
        #1;
        model_reset();
        compare_outputs();
        repeat (3) step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        // Reset state
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_outputs();
        rst = 1'b0;
        step();

        // Fill bank 0 with addr*3, closing on the last write
        for (int a = 0; a < DEPTH; a++) begin
            wr_en   = 1'b1;
            wr_addr = a[AW-1:0];
            wr_data = DW'(a * 3);
            wr_done = (a == DEPTH - 1);
            step();
        end
        idle();
        check("fill0_wr_bank",  DW'(bus1.wr_bank),  DW'(1));
        check("fill0_rd_ready", DW'(bus1.rd_ready), DW'(1));
        check("fill0_wr_ready", DW'(bus1.wr_ready), DW'(1));

        // Single read of address 5 on both latencies
        rd_en   = 1'b1;
        rd_addr = AW'(5);
        step();
        idle();
        check("lat1_vld",     DW'(bus1.rd_vld), DW'(1));
        check("lat1_data",    bus1.rd_data,     DW'(15));
        check("lat2_early",   DW'(bus2.rd_vld), DW'(0));
        step();
        check("lat2_vld",     DW'(bus2.rd_vld), DW'(1));
        check("lat2_data",    bus2.rd_data,     DW'(15));
        check("lat1_one_vld", DW'(bus1.rd_vld), DW'(0));

        // Fill bank 1; last write coincides with read of addr 7 and rd_done on bank 0
        for (int a = 0; a < DEPTH; a++) begin
            wr_en   = 1'b1;
            wr_addr = a[AW-1:0];
            wr_data = DW'(a * 5 + 7);
            wr_done = (a == DEPTH - 1);
            rd_en   = (a == DEPTH - 1);
            rd_done = (a == DEPTH - 1);
            rd_addr = AW'(7);
            step();
        end
        idle();
        check("swap_rd_bank",   DW'(bus1.rd_bank),  DW'(1));
        check("swap_wr_bank",   DW'(bus1.wr_bank),  DW'(0));
        check("swap_rd_ready",  DW'(bus1.rd_ready), DW'(1));
        check("close_rd_vld",   DW'(bus1.rd_vld),   DW'(1));
        check("close_rd_data",  bus1.rd_data,       DW'(21));
        step();
        check("close_rd_l2",    bus2.rd_data,       DW'(21));

        // Back-to-back reads of bank 1
        for (int a = 0; a < 4; a++) begin
            rd_en   = 1'b1;
            rd_addr = a[AW-1:0];
            step();
            check("b2b_vld",  DW'(bus1.rd_vld), DW'(1));
            check("b2b_data", bus1.rd_data,     DW'(a * 5 + 7));
        end
        idle();
        repeat (2) step();

        // Refill bank 0 so both banks are full, then try an illegal write
        for (int a = 0; a < DEPTH; a++) begin
            wr_en   = 1'b1;
            wr_addr = a[AW-1:0];
            wr_data = DW'(a * 3);
            wr_done = (a == DEPTH - 1);
            step();
        end
        idle();
        check("both_full_wr_ready", DW'(bus1.wr_ready), DW'(0));
        wr_en   = 1'b1;
        wr_addr = AW'(3);
        wr_data = 32'hDEAD_BEEF;
        step();
        idle();
        check("err_set_l1", DW'(bus1.err), DW'(1));
        check("err_set_l2", DW'(bus2.err), DW'(1));
        rd_done = 1'b1;
        step();
        rd_done = 1'b0;
        rd_en   = 1'b1;
        rd_addr = AW'(3);
        step();
        idle();
        check("dropped_write", bus1.rd_data, DW'(9));
        repeat (2) step();

        // Legal randomized traffic after a fresh reset
        apply_reset();
        for (int i = 0; i < 800; i++) begin
            wr_en   = ($urandom_range(0, 3) != 0) && !m_full[m_wsel];
            wr_addr = AW'($urandom);
            wr_data = $urandom;
            wr_done = ($urandom_range(0, 15) == 0) && !m_full[m_wsel];
            rd_en   = ($urandom_range(0, 1) == 1) && m_full[m_rsel];
            rd_addr = AW'($urandom);
            rd_done = ($urandom_range(0, 15) == 0) && m_full[m_rsel];
            step();
        end
        idle();
        repeat (3) step();
        check("legal_run_err", DW'(bus1.err), DW'(0));

        // Reset right after an accepted read: no valid may appear afterwards
        if (!m_full[m_rsel]) begin
            wr_done = 1'b1;
            step();
            idle();
        end
        rd_en   = 1'b1;
        rd_addr = AW'($urandom);
        step();
        idle();
        rst = 1'b1;
        #1;
        model_reset();
        compare_outputs();
        check("rst_flush_l2", DW'(bus2.rd_vld), DW'(0));
        repeat (2) step();
        rst = 1'b0;
        repeat (4) step();

        // Randomized traffic including protocol violations
        for (int i = 0; i < 500; i++) begin
            wr_en   = ($urandom_range(0, 1) == 1);
            wr_addr = AW'($urandom);
            wr_data = $urandom;
            wr_done = ($urandom_range(0, 11) == 0);
            rd_en   = ($urandom_range(0, 1) == 1);
            rd_addr = AW'($urandom);
            rd_done = ($urandom_range(0, 11) == 0);
            step();
        end
        idle();
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fm_pingpong_buf.md
Name: fm_pingpong_buf

Overview:
- Parametrised two-bank (ping-pong) feature-map buffer.
- Producer fills one bank while the consumer reads the other.
- Bank ownership swaps through done/ready handshakes. Read-valid tracking has a configurable read latency.
- Replaces the single fixed-width 1024x32 dual-port FM buffer. Sits between a conv/pool layer output and the next layer input. RAM is behaviourally inferred; no vendor IP.

Parameters:
DATA_W, 1024, word width in bits
ADDR_W, 5, address width per bank; depth = 2**ADDR_W
RD_LAT, 1, read latency in cycles; legal values 1 or 2 (2 adds an output register)

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  asynchronous, active-high reset
wr_en  in  1  write strobe into current write bank
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
wr_done  in  1  pulse: producer has finished current write bank
wr_ready  out  1  current write bank is EMPTY and may be written
rd_en  in  1  read strobe from current read bank
rd_addr  in  ADDR_W  read address
rd_done  in  1  pulse: consumer has finished current read bank
rd_ready  out  1  current read bank is FULL and may be read
rd_data  out  DATA_W  read data
rd_vld  out  1  rd_data valid this cycle
wr_bank  out  1  index of current write bank
rd_bank  out  1  index of current read bank
err  out  1  sticky protocol-error flag

Behaviour:
- State:
  - full[1:0]: per-bank flag, 0 = EMPTY, 1 = FULL.
  - wr_sel and rd_sel: 1-bit bank pointers.
  - wr_bank = wr_sel; rd_bank = rd_sel.
  - wr_ready = ~full[wr_sel]; rd_ready = full[rd_sel]. Both are combinational from registers.
- Reset (async, immediate):
  - full = 00, wr_sel = 0, rd_sel = 0.
  - Therefore wr_ready = 1 and rd_ready = 0.
  - rd_vld = 0, rd_data = 0, err = 0, read pipeline flushed.
  - RAM contents are not reset.
- Write: if wr_en & wr_ready, mem[wr_sel][wr_addr] <= wr_data at the clock edge.
- Write bank close: if wr_done & wr_ready, then full[wr_sel] <= 1 and wr_sel toggles.
  - A wr_en in the same cycle as wr_done still writes into the closing bank.
- Read: if rd_en & rd_ready, the read is accepted from bank rd_sel at rd_addr.
  - RD_LAT=1: rd_data/rd_vld are registered on the next edge.
  - RD_LAT=2: one further register stage.
  - rd_vld pulses exactly once per accepted read, RD_LAT cycles later.
  - rd_data holds its last value when rd_vld = 0.
- Read bank close: if rd_done & rd_ready, then full[rd_sel] <= 0 and rd_sel toggles.
  - A rd_en in the same cycle as rd_done is accepted and returns data from the closing bank.
  - In-flight reads complete normally after the swap.
- Simultaneous wr_done and rd_done: both processed in the same cycle.
  - They always address different banks: a bank cannot be both EMPTY and FULL.
- Both banks FULL: wr_ready = 0 (back-pressure to producer).
- Both banks EMPTY: rd_ready = 0.
- Same-address collision cannot occur, because read and write never target the same bank in the same cycle.
- Protocol errors set err, which is sticky until rst:
  - wr_en while !wr_ready: write dropped, RAM unchanged.
  - wr_done while !wr_ready: ignored.
  - rd_en while !rd_ready: no rd_vld produced.
  - rd_done while !rd_ready: ignored.
- Reset mid-operation: pending rd_vld is cleared immediately; no stale valid after reset is released.

Test Plan:
- Reset release -> wr_ready=1, rd_ready=0, wr_bank=0, rd_bank=0, rd_vld=0, err=0.
- Write addr 0..31 with data = addr*3 and wr_done on the last write -> wr_bank=1, rd_ready=1, wr_ready=1. Read addr 5 with RD_LAT=1 -> rd_vld one cycle later, rd_data=15. Repeat with RD_LAT=2 -> two cycles later.
- Fill bank 0 (wr_done), then fill bank 1 (wr_done) -> wr_ready=0. A further wr_en to addr 3 -> err=1, and bank 0 addr 3 unchanged on readback.
- Same cycle: rd_done on bank 0 and wr_done on bank 1 (after bank 1 fill) -> full=10, rd_bank=1, wr_bank=0. Back-to-back reads addr 0..3 -> four consecutive rd_vld pulses with correct bank-1 data.
- Same cycle: rd_en addr 7 and rd_done -> rd_vld still pulses with bank-0 addr 7 data; rd_bank toggles.
- Assert rst one cycle after an accepted read -> rd_vld never asserts, full=00, err=0.
